// File: rtl/if_npc_unit_pkg.sv
// Shared definitions for the instruction-fetch / next-PC stage.
// Next-PC command encoding matches what decode drives on npc_op.
// FSM state encoding used by the fetch controller.
package if_npc_unit_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JUMPR  = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    ISSUE = 2'b01,
    HALT  = 2'b10
  } state_t;

  // Branch offset: sign-extended 16-bit word displacement, scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_npc_unit_npc_calc.sv
// Purpose: next-PC computation from the latched instruction and decode's command.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is only used on a consume edge.
// Ports: instr_pc/instr (latched instruction and its address), npc_op (command),
//        rs_data (register target for JUMPR), npc (computed next PC).
module npc_calc
  import if_npc_unit_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic [31:0] instr,
  input  logic [1:0]  npc_op,
  input  logic [31:0] rs_data,
  output logic [31:0] npc
);

  logic [31:0] p4;
  logic        unused_op_bits;

  assign p4 = instr_pc + 32'd4;

  // The opcode field does not participate in target arithmetic.
  assign unused_op_bits = ^instr[31:26];

  always_comb begin
    npc = p4;
    case (npc_op)
      NPC_PLUS4:  npc = p4;
      NPC_BRANCH: npc = p4 + branch_offset(instr[15:0]);
      NPC_JUMP:   npc = {p4[31:28], instr[25:0], 2'b00};
      NPC_JUMPR:  npc = rs_data;
      default:    npc = p4;
    endcase
  end

endmodule

// File: rtl/if_npc_unit.sv
// Purpose: holds the PC, fetches one instruction at a time and presents it to decode.
// Latency: 2 cycles per instruction minimum (fetch cycle + issue cycle), no speculation.
// Backpressure: waits in FETCH while imem_ready=0; holds instr in ISSUE while id_ready=0.
// Ports: clk/rstn; imem_req/imem_addr/imem_ready/imem_rdata (memory side);
//        instr/instr_pc/instr_valid/op/funct/id_ready/npc_op/rs_data (decode side);
//        misalign (sticky error), retired (consumed-instruction count).
module if_npc_unit
  import if_npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  input  logic             id_ready,
  input  logic [1:0]       npc_op,
  input  logic [31:0]      rs_data,
  output logic             misalign,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  state_t      state_nx;
  logic        run;        // low from reset until the first clock edge with rstn high
  logic [31:0] pc;
  logic [31:0] npc;
  logic        fetch_done;
  logic        consume;

  npc_calc u_npc_calc (
    .instr_pc (instr_pc),
    .instr    (instr),
    .npc_op   (npc_op),
    .rs_data  (rs_data),
    .npc      (npc)
  );

  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    imem_req   = 1'b0;
    fetch_done = 1'b0;
    consume    = 1'b0;
    case (state)
      FETCH: begin
        // Gate the request until reset has been seen released on a clock edge.
        imem_req = run;
        if (run && imem_ready) begin
          fetch_done = 1'b1;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        if (id_ready) begin
          consume  = 1'b1;
          state_nx = (npc[1:0] == 2'b00) ? FETCH : HALT;
        end
      end
      HALT: begin
        state_nx = HALT;
      end
      default: begin
        state_nx = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run         <= 1'b0;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      retired     <= '0;
    end else begin
      run <= 1'b1;
      if (fetch_done) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end
      if (consume) begin
        // A misaligned target is still loaded into pc so it can be inspected.
        pc          <= npc;
        retired     <= retired + CNT_ONE;
        instr_valid <= 1'b0;
        if (npc[1:0] != 2'b00) begin
          misalign <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_npc_unit.sv
module tb_if_npc_unit;
  import if_npc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        id_ready;
  logic [1:0]  npc_op;
  logic [31:0] rs_data;
  logic        misalign;
  logic [31:0] retired;
  logic [31:0] next_word;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = next_word;

  if_npc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .op          (op),
    .funct       (funct),
    .id_ready    (id_ready),
    .npc_op      (npc_op),
    .rs_data     (rs_data),
    .misalign    (misalign),
    .retired     (retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_npc(input logic [31:0] ipc, input logic [31:0] ins,
                                            input logic [1:0] cmd, input logic [31:0] rs);
    logic [31:0] p4;
    int          off;
    p4  = ipc + 32'd4;
    off = $signed(ins[15:0]);
    case (cmd)
      2'b00:   return p4;
      2'b01:   return p4 + 32'(off * 4);
      2'b10:   return (p4 & 32'hF000_0000) | ({6'b0, ins[25:0]} * 32'd4);
      default: return rs;
    endcase
  endfunction

  logic        m_started, m_valid, m_halt, m_mis;
  logic [31:0] m_pc, m_instr, m_ipc, m_ret, m_npc;
  logic        m_req;

  always_comb m_npc = model_npc(m_ipc, m_instr, npc_op, rs_data);
  assign m_req = m_started && !m_valid && !m_halt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_started <= 1'b0;
      m_valid   <= 1'b0;
      m_halt    <= 1'b0;
      m_mis     <= 1'b0;
      m_pc      <= 32'h0;
      m_instr   <= 32'h0;
      m_ipc     <= 32'h0;
      m_ret     <= 32'h0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!m_halt) begin
      if (!m_valid) begin
        if (imem_ready) begin
          m_instr <= next_word;
          m_ipc   <= m_pc;
          m_valid <= 1'b1;
        end
      end else if (id_ready) begin
        m_pc    <= m_npc;
        m_ret   <= m_ret + 32'd1;
        m_valid <= 1'b0;
        if (m_npc[1:0] != 2'b00) begin
          m_halt <= 1'b1;
          m_mis  <= 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    check("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("imem_addr", imem_addr, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr", instr, m_instr);
    check("instr_pc", instr_pc, m_ipc);
    check("op", 32'(op), 32'(m_instr[31:26]));
    check("funct", 32'(funct), 32'(m_instr[5:0]));
    check("misalign", 32'(misalign), 32'(m_mis));
    check("retired", retired, m_ret);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction with zero-wait memory and id_ready=1, starting in FETCH.
  task automatic step(input logic [31:0] word, input logic [1:0] cmd, input logic [31:0] rs);
    next_word = word;
    npc_op    = cmd;
    rs_data   = rs;
    tick();
    tick();
  endtask

  initial begin
    imem_ready = 1'b0;
    id_ready   = 1'b0;
    npc_op     = 2'b00;
    rs_data    = 32'h0;
    next_word  = 32'h0;

    // Reset values
    repeat (2) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_op", 32'(op), 32'd0);

    // Release, stall in FETCH, then reset mid-FETCH
    rstn = 1'b1;
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("req_drop_async", 32'(imem_req), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("rerelease_req", 32'(imem_req), 32'd1);
    check("rerelease_addr", imem_addr, 32'h0);

    // Sequential fetch
    imem_ready = 1'b1;
    id_ready   = 1'b1;
    npc_op     = NPC_PLUS4;
    next_word  = 32'h2000_0001;
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", imem_addr, 32'(i * 4));
      tick();
      check("seq_ipc", instr_pc, 32'(i * 4));
      tick();
    end
    check("seq_retired", retired, 32'd3);

    // Branches
    step(32'h0, NPC_PLUS4, 32'h0);
    step(32'h1000_FFFE, NPC_BRANCH, 32'h0);
    check("branch_back", imem_addr, 32'h0000_000C);
    step(32'h0, NPC_PLUS4, 32'h0);
    step(32'h1000_0003, NPC_BRANCH, 32'h0);
    check("branch_fwd", imem_addr, 32'h0000_0020);

    // Jump and jump-register
    step(32'h0, NPC_JUMPR, 32'h3000_0040);
    check("jr_setup", imem_addr, 32'h3000_0040);
    step({6'h02, 26'h000_0100}, NPC_JUMP, 32'h0);
    check("jump", imem_addr, 32'h3000_0400);
    step(32'h0, NPC_JUMPR, 32'h0000_1234);
    check("jumpr", imem_addr, 32'h0000_1234);

    // PC wrap-around
    step(32'h0, NPC_JUMPR, 32'hFFFF_FFFC);
    step(32'h0, NPC_PLUS4, 32'h0);
    check("pc_wrap", imem_addr, 32'h0);
    check("wrap_retired", retired, 32'd12);

    // Memory wait then decode stall
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("memwait_addr", imem_addr, 32'h0);
      check("memwait_req", 32'(imem_req), 32'd1);
    end
    next_word  = 32'hDEAD_BEEF;
    id_ready   = 1'b0;
    npc_op     = NPC_JUMPR;
    rs_data    = 32'h0000_0003;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_instr", instr, 32'hDEAD_BEEF);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_retired", retired, 32'd12);
    end
    check("stall_op", 32'(op), 32'h37);
    check("stall_funct", 32'(funct), 32'h2F);
    npc_op     = NPC_PLUS4;
    id_ready   = 1'b1;
    imem_ready = 1'b1;
    tick();
    check("after_stall_retired", retired, 32'd13);
    check("after_stall_addr", imem_addr, 32'h4);

    // Misaligned target halts the stage
    step(32'h0, NPC_JUMPR, 32'h0000_0102);
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_retired", retired, 32'd14);
    check("mis_req", 32'(imem_req), 32'd0);
    repeat (4) tick();
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_valid", 32'(instr_valid), 32'd0);
    check("halt_mis", 32'(misalign), 32'd1);

    // Reset out of HALT
    rstn = 1'b0;
    #1;
    check("halt_rst_mis", 32'(misalign), 32'd0);
    check("halt_rst_retired", retired, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("halt_rst_req", 32'(imem_req), 32'd1);
    check("halt_rst_addr", imem_addr, 32'h0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_npc_unit.md
Name: if_npc_unit

Overview:
- Instruction-fetch and next-PC stage that sits directly upstream of the instruction decoder/control unit.
- Holds the PC and fetches instructions from instruction memory with a ready handshake.
- Presents the latched instruction, split into op/funct fields, to decode.
- Applies the 2-bit next-PC command returned by decode to choose the next fetch address.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rstn  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch byte address; equals pc while imem_req=1.
imem_ready  in  1  memory accepts the request and imem_rdata is valid in the same cycle.
imem_rdata  in  32  fetched instruction word.
instr  out  32  latched instruction.
instr_pc  out  32  byte address of instr.
instr_valid  out  1  instr is valid for decode.
op  out  6  instr[31:26].
funct  out  6  instr[5:0].
id_ready  in  1  decode/execute consumes instr this cycle.
npc_op  in  2  next-PC command: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 JUMPR.
rs_data  in  32  register target for JUMPR.
misalign  out  1  sticky flag: a computed next PC had bits [1:0] != 0.
retired  out  CNT_W  count of consumed instructions.

Behaviour:
- Reset is asynchronous and active-low (rstn). On assertion, immediately and regardless of state:
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, instr=0, instr_pc=0, instr_valid=0, misalign=0, retired=0.
- While rstn=0: imem_req=0. The first request is raised in the first cycle after rstn is sampled high.
- States: FETCH, ISSUE, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - If imem_ready=1 on a rising edge: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, next state ISSUE.
  - Otherwise stay in FETCH, holding imem_req and imem_addr stable.
- ISSUE:
  - imem_req=0, instr_valid=1, instr and instr_pc held stable.
  - npc_op and rs_data are sampled only while instr_valid=1 and id_ready=1; they are ignored at all other times.
  - On a consume edge: pc<=npc, retired<=retired+1, instr_valid<=0.
    - If npc[1:0]==0: next state FETCH.
    - Else: misalign<=1, pc<=npc (kept for debug), next state HALT.
  - If id_ready=0: hold all outputs; no counter change.
- HALT:
  - imem_req=0, instr_valid=0.
  - Leaves HALT only via reset; misalign stays 1.
- Next-PC computation (combinational, all 32-bit, carries out of bit 31 discarded):
  - p4 = instr_pc + 4.
  - PLUS4: npc = p4.
  - BRANCH: npc = p4 + (sign_extend(instr[15:0]) << 2).
  - JUMP: npc = {p4[31:28], instr[25:0], 2'b00}.
  - JUMPR: npc = rs_data.
- Throughput: at least 2 cycles per instruction; exactly 2 with zero-wait memory and id_ready=1.
- Wrap-around:
  - pc 32'hFFFF_FFFC with PLUS4 yields 0.
  - retired wraps from all-ones to 0.
- op and funct are combinational slices of instr, so they are 0 after reset.
- imem_ready while not in FETCH is ignored.
- The stage never issues a speculative fetch: fetch of the next instruction starts only after the current one is consumed.

Decomposition:
- Shared package holds:
  - NPC_PLUS4/NPC_BRANCH/NPC_JUMP/NPC_JUMPR 2-bit constants, the same encoding decode drives.
  - State encodings FETCH=2'b00, ISSUE=2'b01, HALT=2'b10.
- One sub-module is natural: npc_calc, purely combinational, with inputs instr_pc, instr, npc_op, rs_data and output npc.
- The top holds the FSM, the PC and instruction registers, and the counter.

Test Plan:
1. Reset:
   - Stimulus: assert rstn=0 mid-FETCH, then release.
   - Response: imem_req drops immediately; after release, imem_addr=0; all outputs equal their reset values.
2. Sequential fetch:
   - Stimulus: zero-wait memory, id_ready=1, npc_op=00.
   - Response: imem_addr sequence 0,4,8 on every other cycle; retired=3 after 6 cycles.
3. Branch:
   - Stimulus: instr_pc=0x10, instr[15:0]=16'hFFFE, npc_op=01.
   - Response: next imem_addr=0x0C.
   - Same test with imm 0x0003: next imem_addr=0x20.
4. Jump and jump-register:
   - Stimulus: instr_pc=0x3000_0040, instr[25:0]=26'h000_0100, npc_op=10.
   - Response: next addr=0x3000_0400.
   - Stimulus: npc_op=11 with rs_data=0x0000_1234.
   - Response: next addr=0x1234.
5. Handshake stalls:
   - Stimulus: imem_ready low for 3 cycles, then id_ready low for 2 cycles.
   - Response: imem_addr stable during the memory wait; instr, instr_valid and retired unchanged during the decode stall.
6. Misalign:
   - Stimulus: npc_op=11, rs_data=0x0000_0102.
   - Response: misalign=1 and state HALT; imem_req stays 0 until reset; retired still incremented by 1.
